computer_move_generator: RTL and testbench

Automatic opponent for the tic-tac-toe game core: it drives the game's computer-side move inputs (`computer_position`, `pc`) from the stored board. When the top level requests a computer move, it snapshots the nine position registers and scans the board over several cycles: first for a winning move, then for a block, then by positional preference. It then issues the chosen cell as a single-cycle `pc` strobe with a stable position code.

---
 rtl/computer_move_generator.sv | 183 ++++++++++++++++++
 tb/tb_computer_move_generator.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/computer_move_generator.sv
// Computer opponent for the tic-tac-toe core: snapshots the board on request,
// scans for a win, then a block, then a positional pick, and strobes the chosen cell.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | waiting for move_req; captures the board snapshot
// S_SCAN_WIN   | evaluating line line_idx for a computer (10) completion
// S_SCAN_BLOCK | evaluating line line_idx for a player (01) completion
// S_PICK       | first empty cell in order 4,0,2,6,8,1,3,5,7
// S_ISSUE      | pc high, computer_position valid
// S_WAIT_REL   | move done; waiting for move_req to drop
module computer_move_generator (
    input  logic       clock,
    input  logic       reset,
    input  logic       move_req,
    input  logic [1:0] pos1,
    input  logic [1:0] pos2,
    input  logic [1:0] pos3,
    input  logic [1:0] pos4,
    input  logic [1:0] pos5,
    input  logic [1:0] pos6,
    input  logic [1:0] pos7,
    input  logic [1:0] pos8,
    input  logic [1:0] pos9,
    output logic [3:0] computer_position,
    output logic       pc,
    output logic       busy,
    output logic       no_move
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SCAN_WIN   = 3'd1;
    localparam logic [2:0] S_SCAN_BLOCK = 3'd2;
    localparam logic [2:0] S_PICK       = 3'd3;
    localparam logic [2:0] S_ISSUE      = 3'd4;
    localparam logic [2:0] S_WAIT_REL   = 3'd5;

    localparam logic [1:0] CELL_EMPTY    = 2'b00;
    localparam logic [1:0] CELL_PLAYER   = 2'b01;
    localparam logic [1:0] CELL_COMPUTER = 2'b10;

    logic [2:0]  state;
    logic [2:0]  line_idx;
    logic [17:0] snap;

    logic [3:0]  c0, c1, c2;
    logic [1:0]  va, vb, vc;
    logic [1:0]  side;
    logic        line_hit;
    logic [3:0]  line_target;
    logic        pick_found;
    logic [3:0]  pick_target;

    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
        logic [1:0] v;
        case (idx)
            4'd0:    v = b[1:0];
            4'd1:    v = b[3:2];
            4'd2:    v = b[5:4];
            4'd3:    v = b[7:6];
            4'd4:    v = b[9:8];
            4'd5:    v = b[11:10];
            4'd6:    v = b[13:12];
            4'd7:    v = b[15:14];
            4'd8:    v = b[17:16];
            default: v = 2'b11;
        endcase
        return v;
    endfunction

    always_comb begin
        c0 = 4'd0;
        c1 = 4'd1;
        c2 = 4'd2;
        case (line_idx)
            3'd0: begin c0 = 4'd0; c1 = 4'd1; c2 = 4'd2; end
            3'd1: begin c0 = 4'd3; c1 = 4'd4; c2 = 4'd5; end
            3'd2: begin c0 = 4'd6; c1 = 4'd7; c2 = 4'd8; end
            3'd3: begin c0 = 4'd0; c1 = 4'd3; c2 = 4'd6; end
            3'd4: begin c0 = 4'd1; c1 = 4'd4; c2 = 4'd7; end
            3'd5: begin c0 = 4'd2; c1 = 4'd5; c2 = 4'd8; end
            3'd6: begin c0 = 4'd0; c1 = 4'd4; c2 = 4'd8; end
            default: begin c0 = 4'd2; c1 = 4'd4; c2 = 4'd6; end
        endcase
    end

    // 11 never equals either side and is never empty, so it always breaks a line
    always_comb begin
        side        = (state == S_SCAN_WIN) ? CELL_COMPUTER : CELL_PLAYER;
        va          = cell_at(snap, c0);
        vb          = cell_at(snap, c1);
        vc          = cell_at(snap, c2);
        line_hit    = 1'b0;
        line_target = 4'd0;
        if (va == side && vb == side && vc == CELL_EMPTY) begin
            line_hit    = 1'b1;
            line_target = c2;
        end else if (va == side && vc == side && vb == CELL_EMPTY) begin
            line_hit    = 1'b1;
            line_target = c1;
        end else if (vb == side && vc == side && va == CELL_EMPTY) begin
            line_hit    = 1'b1;
            line_target = c0;
        end
    end

    // Evaluated lowest priority first so the highest-priority empty cell wins
    always_comb begin
        pick_found  = 1'b0;
        pick_target = 4'd0;
        if (cell_at(snap, 4'd7) == CELL_EMPTY) begin pick_found = 1'b1; pick_target = 4'd7; end
        if (cell_at(snap, 4'd5) == CELL_EMPTY) begin pick_found = 1'b1; pick_target = 4'd5; end
        if (cell_at(snap, 4'd3) == CELL_EMPTY) begin pick_found = 1'b1; pick_target = 4'd3; end
        if (cell_at(snap, 4'd1) == CELL_EMPTY) begin pick_found = 1'b1; pick_target = 4'd1; end
        if (cell_at(snap, 4'd8) == CELL_EMPTY) begin pick_found = 1'b1; pick_target = 4'd8; end
        if (cell_at(snap, 4'd6) == CELL_EMPTY) begin pick_found = 1'b1; pick_target = 4'd6; end
        if (cell_at(snap, 4'd2) == CELL_EMPTY) begin pick_found = 1'b1; pick_target = 4'd2; end
        if (cell_at(snap, 4'd0) == CELL_EMPTY) begin pick_found = 1'b1; pick_target = 4'd0; end
        if (cell_at(snap, 4'd4) == CELL_EMPTY) begin pick_found = 1'b1; pick_target = 4'd4; end
    end

    assign busy = (state == S_SCAN_WIN) || (state == S_SCAN_BLOCK) ||
                  (state == S_PICK)     || (state == S_ISSUE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            line_idx          <= 3'd0;
            snap              <= 18'd0;
            computer_position <= 4'd0;
            pc                <= 1'b0;
            no_move           <= 1'b0;
        end else begin
            pc      <= 1'b0;
            no_move <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (move_req) begin
                        snap     <= {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
                        line_idx <= 3'd0;
                        state    <= S_SCAN_WIN;
                    end
                end
                S_SCAN_WIN, S_SCAN_BLOCK: begin
                    if (!move_req) begin
                        state <= S_IDLE;
                    end else if (line_hit) begin
                        computer_position <= line_target;
                        pc                <= 1'b1;
                        state             <= S_ISSUE;
                    end else if (line_idx == 3'd7) begin
                        line_idx <= 3'd0;
                        state    <= (state == S_SCAN_WIN) ? S_SCAN_BLOCK : S_PICK;
                    end else begin
                        line_idx <= line_idx + 3'd1;
                    end
                end
                S_PICK: begin
                    if (!move_req) begin
                        state <= S_IDLE;
                    end else if (pick_found) begin
                        computer_position <= pick_target;
                        pc                <= 1'b1;
                        state             <= S_ISSUE;
                    end else begin
                        no_move <= 1'b1;
                        state   <= S_WAIT_REL;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT_REL;
                end
                S_WAIT_REL: begin
                    if (!move_req) state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_computer_move_generator.sv
// Directed bench for computer_move_generator: request latency, chosen cell,
// strobe uniqueness, abort and asynchronous reset behaviour.
module tb_computer_move_generator;

    logic        clock;
    logic        reset;
    logic        move_req;
    logic [17:0] board;
    logic [3:0]  computer_position;
    logic        pc;
    logic        busy;
    logic        no_move;

    int tests;
    int fails;

    computer_move_generator dut (
        .clock             (clock),
        .reset             (reset),
        .move_req          (move_req),
        .pos1              (board[1:0]),
        .pos2              (board[3:2]),
        .pos3              (board[5:4]),
        .pos4              (board[7:6]),
        .pos5              (board[9:8]),
        .pos6              (board[11:10]),
        .pos7              (board[13:12]),
        .pos8              (board[15:14]),
        .pos9              (board[17:16]),
        .computer_position (computer_position),
        .pc                (pc),
        .busy              (busy),
        .no_move           (no_move)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [1:0] E = 2'b00;
    localparam logic [1:0] P = 2'b01;
    localparam logic [1:0] C = 2'b10;
    localparam logic [1:0] Z = 2'b11;

    function automatic logic [17:0] mkb(input logic [1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Raises move_req so the next edge is E0, optionally changes the board right
    // after E0, and checks which edge produced the strobe and what it carried.
    task automatic do_req(input string tag, input logic [17:0] b, input logic [17:0] b_after,
                          input int exp_edge, input logic exp_pc, input logic [3:0] exp_pos);
        int k;
        int extra;
        logic seen;
        @(negedge clock);
        board    = b;
        move_req = 1'b1;
        @(posedge clock);
        #1 board = b_after;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 30) begin
            @(posedge clock);
            k++;
            #1;
            if (pc || no_move) seen = 1'b1;
        end
        check({tag, " edge"}, k, exp_edge);
        check({tag, " pc"}, int'(pc), int'(exp_pc));
        check({tag, " no_move"}, int'(no_move), int'(!exp_pc));
        if (exp_pc) check({tag, " position"}, int'(computer_position), int'(exp_pos));
        @(negedge clock);
        if (exp_pc) check({tag, " position mid-cycle"}, int'(computer_position), int'(exp_pos));
        extra = 0;
        repeat (8) begin
            @(posedge clock);
            #1;
            if (pc || no_move) extra++;
        end
        check({tag, " strobes while held"}, extra, 0);
        check({tag, " busy in wait"}, int'(busy), 0);
        @(negedge clock);
        move_req = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int extra;
        tests    = 0;
        fails    = 0;
        reset    = 1'b1;
        move_req = 1'b0;
        board    = 18'd0;
        #12;
        check("reset position", int'(computer_position), 0);
        check("reset pc", int'(pc), 0);
        check("reset busy", int'(busy), 0);
        check("reset no_move", int'(no_move), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Win on L0 at E1; board cleared after E0 must not matter
        do_req("win L0", mkb(C, C, E, E, E, E, E, E, E), 18'd0, 1, 1'b1, 4'd2);
        // Win on the last line L7 -> E8
        do_req("win L7", mkb(E, E, C, E, C, E, E, E, E), mkb(E, E, C, E, C, E, E, E, E), 8, 1'b1, 4'd6);
        // Block on L1 -> E10, board change after E0 ignored
        do_req("block L1", mkb(C, E, E, P, P, E, E, E, E), 18'd0, 10, 1'b1, 4'd5);
        // Block on L7 -> E16
        do_req("block L7", mkb(E, E, P, E, P, E, E, E, E), mkb(E, E, P, E, P, E, E, E, E), 16, 1'b1, 4'd6);
        // Win beats block
        do_req("win over block", mkb(P, P, E, E, E, E, C, C, E), mkb(P, P, E, E, E, E, C, C, E), 3, 1'b1, 4'd8);
        // Preference picks
        do_req("pick empty", 18'd0, 18'd0, 17, 1'b1, 4'd4);
        do_req("pick centre taken", mkb(E, E, E, E, P, E, E, E, E), mkb(E, E, E, E, P, E, E, E, E), 17, 1'b1, 4'd0);
        // 11 is occupied and breaks the L0 win
        do_req("code 11", mkb(Z, C, C, E, E, E, E, E, E), mkb(Z, C, C, E, E, E, E, E, E), 17, 1'b1, 4'd4);
        // Full draw board -> no_move, no pc
        do_req("full board", mkb(C, P, C, C, P, P, P, C, C), mkb(C, P, C, C, P, P, P, C, C), 17, 1'b0, 4'd0);

        // Abort: drop move_req so that E5 samples it low
        @(negedge clock);
        board    = 18'd0;
        move_req = 1'b1;
        @(posedge clock);
        repeat (4) @(posedge clock);
        #1 check("abort busy before", int'(busy), 1);
        @(negedge clock);
        move_req = 1'b0;
        @(posedge clock);
        #1 check("abort busy after", int'(busy), 0);
        extra = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (pc || no_move) extra++;
        end
        check("abort strobes", extra, 0);
        check("abort position kept", int'(computer_position), 4);

        // Async reset between E3 and E4 of an L7-win request
        @(negedge clock);
        board    = mkb(E, E, C, E, C, E, E, E, E);
        move_req = 1'b1;
        @(posedge clock);
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("reset mid busy", int'(busy), 0);
        check("reset mid position", int'(computer_position), 0);
        check("reset mid pc", int'(pc), 0);
        check("reset mid no_move", int'(no_move), 0);
        move_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        extra = 0;
        repeat (10) begin
            @(posedge clock);
            #1;
            if (pc || no_move) extra++;
        end
        check("reset no late strobe", extra, 0);
        do_req("after reset", mkb(C, C, E, E, E, E, E, E, E), mkb(C, C, E, E, E, E, E, E, E), 1, 1'b1, 4'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
